// File: rtl/cpu_seq_ctrl.sv
// CPU sequencing controller: gates fetch/decode/execute and drives PC reset/branch.
// Optional resume-from-halt is built when CPU_SEQ_RESUME_EN is defined.
module cpu_seq_ctrl #(
  parameter int unsigned BRANCH_FLUSH  = 1,
  parameter int unsigned STACK_TIMEOUT = 15,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] decode2cpu_ctrl_cmd,
  input  logic [2:0] cbr_status,
  input  logic       resume,
  output logic       ifetch_en,
  output logic       idecode_en,
  output logic       execute_en,
  output logic       pc_reset,
  output logic       pc_branch,
  output logic       stack_fault,
  output logic [2:0] cpu_state
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_RUN      = 3'd1,
    S_HALT     = 3'd2,
    S_BRANCH   = 3'd3,
    S_STACK_OP = 3'd5,
    S_FAULT    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(BRANCH_FLUSH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stack_fault_q, stack_fault_d;

  logic soft_rst_s, halted_s, exec_en_s, fetch_en_s;
  logic call_s, branch_s, ret_s;

  assign {soft_rst_s, halted_s, exec_en_s, fetch_en_s} = decode2cpu_ctrl_cmd;
  assign {call_s, branch_s, ret_s} = cbr_status;

`ifndef CPU_SEQ_RESUME_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  // State, counter and sticky fault registers
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q       <= S_INIT;
      cnt_q         <= CNT_ZERO;
      stack_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stack_fault_q <= stack_fault_d;
    end
  end

  // Next-state, counter and fault-flag logic; reset overrides so pc_reset sees INIT
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stack_fault_d = stack_fault_q;
    case (state_q)
      S_INIT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halted_s) begin
          state_d = S_HALT;
        end else if (soft_rst_s) begin
          state_d = S_INIT;
        end else if ((cbr_status == 3'b001) || (cbr_status == 3'b100)) begin
          state_d = S_STACK_OP;
          cnt_d   = CNT_ZERO;
        end else if (cbr_status == 3'b010) begin
          state_d = S_BRANCH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_BRANCH: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_STACK_OP: begin
        // A branch on the expiring cycle wins over the watchdog
        if (branch_s) begin
          state_d = S_BRANCH;
          cnt_d   = FLUSH_LOAD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = S_FAULT;
          stack_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FAULT: begin
        if (soft_rst_s) begin
          state_d = S_INIT;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_HALT: begin
`ifdef CPU_SEQ_RESUME_EN
        if (resume) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
`else
        state_d = S_HALT;
`endif
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    if (!reset_) begin
      state_d       = S_INIT;
      cnt_d         = CNT_ZERO;
      stack_fault_d = 1'b0;
    end
  end

  // Combinational pipeline enables and PC controls
  always_comb begin
    ifetch_en  = 1'b0;
    idecode_en = 1'b0;
    execute_en = 1'b0;
    pc_reset   = (state_d == S_INIT);
    pc_branch  = (state_d == S_BRANCH) && (state_q != S_BRANCH);
    if (reset_) begin
      ifetch_en  = fetch_en_s && (state_q != S_STACK_OP) && (state_q != S_FAULT);
      idecode_en = (state_q == S_RUN);
      execute_en = exec_en_s && (state_q != S_FAULT);
    end else begin
      ifetch_en  = 1'b0;
      idecode_en = 1'b0;
      execute_en = 1'b0;
    end
  end

  assign stack_fault = stack_fault_q;
  assign cpu_state   = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl (BRANCH_FLUSH=3, STACK_TIMEOUT=15).
module tb_cpu_seq_ctrl;

  localparam int BF = 3;
  localparam int ST = 15;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] cmd;
  logic [2:0] cbr;
  logic       resume;
  logic       ifetch_en, idecode_en, execute_en, pc_reset, pc_branch, stack_fault;
  logic [2:0] cpu_state;

  cpu_seq_ctrl #(.BRANCH_FLUSH(BF), .STACK_TIMEOUT(ST), .CNT_W(4)) dut (
    .clk                 (clk),
    .reset_              (reset_),
    .decode2cpu_ctrl_cmd (cmd),
    .cbr_status          (cbr),
    .resume              (resume),
    .ifetch_en           (ifetch_en),
    .idecode_en          (idecode_en),
    .execute_en          (execute_en),
    .pc_reset            (pc_reset),
    .pc_branch           (pc_branch),
    .stack_fault         (stack_fault),
    .cpu_state           (cpu_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic f, d, e, pr, pb, sf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  int m_state = 0;
  int m_cnt   = 0;
  bit m_fault = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // one clock cycle: drive inputs, push model prediction, compare at negedge, advance model
  task automatic step(input logic rst, input logic [3:0] c, input logic [2:0] b,
                      input logic res, input string tag);
    int ns, nc;
    bit nf;
    exp_t e, got;
    reset_ = rst; cmd = c; cbr = b; resume = res;
    ns = m_state; nc = m_cnt; nf = m_fault;
    if (!rst) begin
      ns = 0; nc = 0; nf = 1'b0;
    end else begin
      case (m_state)
        0: ns = 1;
        1: begin
          if (c[2]) ns = 2;
          else if (c[3]) ns = 0;
          else if (b == 3'b001 || b == 3'b100) begin ns = 5; nc = 0; end
          else if (b == 3'b010) begin ns = 3; nc = BF - 1; end
        end
        3: begin
          if (m_cnt != 0) nc = m_cnt - 1;
          else ns = 1;
        end
        5: begin
          if (b[1]) begin ns = 3; nc = BF - 1; end
          else if (m_cnt == ST - 1) begin ns = 6; nf = 1'b1; end
          else nc = m_cnt + 1;
        end
        6: if (c[3]) ns = 0;
        2: begin
`ifdef CPU_SEQ_RESUME_EN
          if (res) ns = 1;
`endif
        end
        default: ns = 0;
      endcase
    end
    e.st = 3'(m_state);
    e.f  = rst && c[0] && m_state != 5 && m_state != 6;
    e.d  = rst && m_state == 1;
    e.e  = rst && c[1] && m_state != 6;
    e.pr = (ns == 0);
    e.pb = (ns == 3) && (m_state != 3);
    e.sf = m_fault;
    sb_q.push_back(e);
    @(negedge clk);
    got = {cpu_state, ifetch_en, idecode_en, execute_en, pc_reset, pc_branch, stack_fault};
    check_eq(tag, 32'(got), 32'(sb_q.pop_front()));
    @(posedge clk);
    #1;
    m_state = ns; m_cnt = nc; m_fault = nf;
  endtask

  initial begin
    reset_ = 1'b0; cmd = 4'b0001; cbr = 3'b000; resume = 1'b0;
    @(posedge clk);
    #1;
    // reset then idle
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 3'b000, 1'b0, "reset");
    step(1'b1, 4'b0011, 3'b000, 1'b0, "init");
    check_eq("run_after_reset", 32'(cpu_state), 32'd1);
    check_eq("idecode_after_reset", 32'(idecode_en), 32'd1);
    // branch flush
    step(1'b1, 4'b0011, 3'b010, 1'b0, "br_take");
    for (int i = 0; i < BF; i++) begin
      check_eq("br_flush_state", 32'(cpu_state), 32'd3);
      step(1'b1, 4'b0011, 3'b000, 1'b0, "br_flush");
    end
    step(1'b1, 4'b0011, 3'b000, 1'b0, "br_run");
    // call then branch four cycles later
    step(1'b1, 4'b0011, 3'b100, 1'b0, "call");
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0011, 3'b000, 1'b0, "call_wait");
    check_eq("call_ifetch_off", 32'(ifetch_en), 32'd0);
    step(1'b1, 4'b0011, 3'b010, 1'b0, "call_br");
    for (int i = 0; i < BF + 1; i++) step(1'b1, 4'b0011, 3'b000, 1'b0, "call_ret");
    check_eq("call_no_fault", 32'(stack_fault), 32'd0);
    // illegal / multi-hot cbr in RUN
    step(1'b1, 4'b0011, 3'b111, 1'b0, "cbr_111");
    step(1'b1, 4'b0011, 3'b011, 1'b0, "cbr_011");
    check_eq("cbr_illegal_run", 32'(cpu_state), 32'd1);
    // branch on the expiring watchdog cycle
    step(1'b1, 4'b0011, 3'b001, 1'b0, "ret_race");
    for (int i = 0; i < ST - 1; i++) step(1'b1, 4'b1111 & 4'b0011, 3'b000, 1'b0, "race_wait");
    step(1'b1, 4'b0011, 3'b010, 1'b0, "race_br");
    check_eq("race_state", 32'(cpu_state), 32'd3);
    check_eq("race_no_fault", 32'(stack_fault), 32'd0);
    for (int i = 0; i < BF; i++) step(1'b1, 4'b0011, 3'b000, 1'b0, "race_flush");
    // reset mid-BRANCH aborts the flush
    step(1'b1, 4'b0011, 3'b010, 1'b0, "abort_br");
    step(1'b0, 4'b0011, 3'b000, 1'b0, "abort_rst");
    step(1'b1, 4'b0011, 3'b000, 1'b0, "abort_init");
    step(1'b1, 4'b0011, 3'b000, 1'b0, "abort_run");
    // watchdog; soft_rst/halted ignored in STACK_OP
    step(1'b1, 4'b0011, 3'b001, 1'b0, "wd_ret");
    for (int i = 0; i < ST; i++)
      step(1'b1, (i == 2) ? 4'b1111 : 4'b0011, 3'b000, 1'b0, "wd_wait");
    check_eq("wd_state", 32'(cpu_state), 32'd6);
    check_eq("wd_fault", 32'(stack_fault), 32'd1);
    check_eq("wd_exec_off", 32'(execute_en), 32'd0);
    step(1'b1, 4'b0011, 3'b000, 1'b0, "fault_hold");
    step(1'b1, 4'b1011, 3'b000, 1'b0, "fault_srst");
    step(1'b1, 4'b0011, 3'b000, 1'b0, "fault_init");
    check_eq("srst_keeps_fault", 32'(stack_fault), 32'd1);
    step(1'b1, 4'b0011, 3'b000, 1'b0, "fault_run");
    // halted + soft_rst together, then resume
    step(1'b1, 4'b1111, 3'b000, 1'b0, "halt_srst");
    check_eq("halt_state", 32'(cpu_state), 32'd2);
    step(1'b1, 4'b1011, 3'b000, 1'b1, "resume");
`ifdef CPU_SEQ_RESUME_EN
    check_eq("resume_state", 32'(cpu_state), 32'd1);
`else
    check_eq("resume_state", 32'(cpu_state), 32'd2);
`endif
    step(1'b1, 4'b0011, 3'b000, 1'b0, "post_resume");
    step(1'b0, 4'b0011, 3'b000, 1'b0, "rst_clear");
    check_eq("rst_clears_fault", 32'(stack_fault), 32'd0);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic [3:0] c;
      r = ($urandom_range(0, 19) != 0);
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) != 0) c[2] = 1'b0;
      if ($urandom_range(0, 3) != 0) c[3] = 1'b0;
      step(r, c, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
